// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [SEL_W-1:0] onehot_to_sel(input logic [NUM_REQ-1:0] oh);
    logic [SEL_W-1:0] sel;
    case (oh)
      4'b0001: sel = 2'b00;
      4'b0010: sel = 2'b01;
      4'b0100: sel = 2'b10;
      4'b1000: sel = 2'b11;
      default: sel = 2'b00;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mux_4to1.sv
// Shared 4:1 single-bit data mux; {s1,s0} picks A..D.
module mux_4to1 (
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  input  logic s0,
  input  logic s1,
  output logic out
);

  always_comb begin
    case ({s1, s0})
      2'b00:   out = A;
      2'b01:   out = B;
      2'b10:   out = C;
      2'b11:   out = D;
      default: out = A;
    endcase
  end

endmodule

// File: rtl/mux_4to1_arbiter.sv
// Round-robin arbiter sharing one mux_4to1 among four requesters.
// Define MUX_ARB_HOLD_LIMIT_EN to force rotation after MAX_HOLD grant cycles.
module mux_4to1_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  output logic [3:0] grant,
  output logic       valid,
  output logic       s0,
  output logic       s1,
  output logic       out
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** HOLD_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("mux_4to1_arbiter: illegal MAX_HOLD/HOLD_W combination");
  end

  // Returns {found, index}; the search starts just after start_after and wraps,
  // so the previous winner has lowest priority.
  function automatic logic [SEL_W:0] arbitrate(
    input logic [NUM_REQ-1:0] r,
    input logic [SEL_W-1:0]   start_after,
    input logic               excl_en,
    input logic [SEL_W-1:0]   excl_idx
  );
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] idx;
    res = {(SEL_W + 1){1'b0}};
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = start_after + SEL_W'(i);
      if (r[idx] && !(excl_en && (idx == excl_idx))) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_grant, w_grant_nxt;
  logic             r_valid;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic [SEL_W-1:0] r_last, w_last_nxt;
  logic [SEL_W:0]   w_win_free;
  logic [SEL_W:0]   w_win_excl;

`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
`endif

  assign w_win_free = arbitrate(req, r_last, 1'b0, r_last);
  assign w_win_excl = arbitrate(req, r_last, 1'b1, r_last);

  // Next-state, next-grant and select decision.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_sel_nxt   = r_sel;
`ifdef MUX_ARB_HOLD_LIMIT_EN
    w_hold_nxt  = r_hold_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (w_win_free[SEL_W]) begin
          w_grant_nxt = 4'b0001 << w_win_free[SEL_W-1:0];
          w_last_nxt  = w_win_free[SEL_W-1:0];
          w_sel_nxt   = onehot_to_sel(4'b0001 << w_win_free[SEL_W-1:0]);
          w_state_nxt = BUSY;
`ifdef MUX_ARB_HOLD_LIMIT_EN
          w_hold_nxt  = {HOLD_W{1'b0}};
`endif
        end else begin
          w_grant_nxt = 4'b0000;
        end
      end
      BUSY: begin
        // r_last always names the current holder while BUSY.
        if (!req[r_last]) begin
          if (w_win_excl[SEL_W]) begin
            w_grant_nxt = 4'b0001 << w_win_excl[SEL_W-1:0];
            w_last_nxt  = w_win_excl[SEL_W-1:0];
            w_sel_nxt   = onehot_to_sel(4'b0001 << w_win_excl[SEL_W-1:0]);
`ifdef MUX_ARB_HOLD_LIMIT_EN
            w_hold_nxt  = {HOLD_W{1'b0}};
`endif
          end else begin
            w_grant_nxt = 4'b0000;
            w_state_nxt = IDLE;
          end
        end else begin
`ifdef MUX_ARB_HOLD_LIMIT_EN
          if (r_hold_cnt < HOLD_LAST) begin
            w_hold_nxt = r_hold_cnt + HOLD_W'(1);
          end else if (w_win_excl[SEL_W]) begin
            w_grant_nxt = 4'b0001 << w_win_excl[SEL_W-1:0];
            w_last_nxt  = w_win_excl[SEL_W-1:0];
            w_sel_nxt   = onehot_to_sel(4'b0001 << w_win_excl[SEL_W-1:0]);
            w_hold_nxt  = {HOLD_W{1'b0}};
          end else begin
            w_hold_nxt  = HOLD_LAST;
          end
`else
          w_grant_nxt = r_grant;
`endif
        end
      end
      default: begin
        w_grant_nxt = 4'b0000;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Arbiter state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= 4'b0000;
      r_valid <= 1'b0;
      r_sel   <= 2'b00;
      r_last  <= 2'b11;
`ifdef MUX_ARB_HOLD_LIMIT_EN
      r_hold_cnt <= {HOLD_W{1'b0}};
`endif
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_valid <= |w_grant_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
`ifdef MUX_ARB_HOLD_LIMIT_EN
      r_hold_cnt <= w_hold_nxt;
`endif
    end
  end

  assign grant = r_grant;
  assign valid = r_valid;
  assign s1    = r_sel[1];
  assign s0    = r_sel[0];

  mux_4to1 u_mux (
    .A  (A),
    .B  (B),
    .C  (C),
    .D  (D),
    .s0 (s0),
    .s1 (s1),
    .out(out)
  );

endmodule

// File: tb/tb_mux_4to1_arbiter.sv
// Scoreboard bench for mux_4to1_arbiter; expectations follow MUX_ARB_HOLD_LIMIT_EN.
module tb_mux_4to1_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       A, B, C, D;
  logic [3:0] grant;
  logic       valid, s0, s1, out;

  logic [7:0] exp_q[$];
  string      name_q[$];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  mux_4to1_arbiter #(.MAX_HOLD(4), .HOLD_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .A    (A),
    .B    (B),
    .C    (C),
    .D    (D),
    .grant(grant),
    .valid(valid),
    .s0   (s0),
    .s1   (s1),
    .out  (out)
  );

  task automatic compare(input string nm, input logic [7:0] act, input logic [7:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got grant=%b valid=%b s1s0=%b out=%b, want grant=%b valid=%b s1s0=%b out=%b",
               nm, act[7:4], act[3], act[2:1], act[0], expv[7:4], expv[3], expv[2:1], expv[0]);
    end
  endtask

  // Monitor: one expected entry is consumed just after each rising edge.
  always @(posedge clk) begin
    logic [7:0] e;
    string      n;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      compare(n, {grant, valid, s1, s0, out}, e);
    end
  end

  task automatic step(input string nm, input logic [3:0] r, input logic [3:0] dcba,
                      input logic [3:0] eg, input logic [1:0] esel, input logic eo);
    @(negedge clk);
    req = r;
    {D, C, B, A} = dcba;
    exp_q.push_back({eg, |eg, esel, eo});
    name_q.push_back(nm);
  endtask

  initial begin
    logic [3:0] eg;
    rst = 1'b1;
    req = 4'b0000;
    {D, C, B, A} = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    compare("reset_state", {grant, valid, s1, s0, out}, 8'b0000_0_00_0);

    // Single requester, then release keeps selects.
    step("single",       4'b0010, 4'b0101, 4'b0010, 2'b01, 1'b0);
    step("single_hold",  4'b0010, 4'b0101, 4'b0010, 2'b01, 1'b0);
    step("single_rel",   4'b0000, 4'b0010, 4'b0000, 2'b01, 1'b1);

    // Grant then asynchronous reset mid-cycle.
    step("pre_rst",      4'b0100, 4'b0100, 4'b0100, 2'b10, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    compare("async_rst", {grant, valid, s1, s0, out}, 8'b0000_0_00_0);
    @(negedge clk);
    req = 4'b0000;
    rst = 1'b0;

    // Round-robin with each holder dropping after one cycle.
    step("rr0",          4'b1111, 4'b1010, 4'b0001, 2'b00, 1'b0);
    step("rr1",          4'b1110, 4'b1010, 4'b0010, 2'b01, 1'b1);
    step("rr2",          4'b1101, 4'b1010, 4'b0100, 2'b10, 1'b0);
    step("rr3",          4'b1011, 4'b1010, 4'b1000, 2'b11, 1'b1);
    step("rr4",          4'b0111, 4'b1010, 4'b0001, 2'b00, 1'b0);
    step("rr_idle",      4'b0000, 4'b1010, 4'b0000, 2'b00, 1'b0);

    // Holder 2 releases while requester 3 waits: one-edge handover.
    step("ho_grant",     4'b0100, 4'b1000, 4'b0100, 2'b10, 1'b0);
    step("ho_keep",      4'b1100, 4'b1000, 4'b0100, 2'b10, 1'b0);
    step("handover",     4'b1000, 4'b1000, 4'b1000, 2'b11, 1'b1);
    step("ho_idle",      4'b0000, 4'b1000, 4'b0000, 2'b11, 1'b1);

    // Two requesters held continuously.
    for (int k = 0; k < 10; k++) begin
`ifdef MUX_ARB_HOLD_LIMIT_EN
      eg = (k < 4 || k >= 8) ? 4'b0001 : 4'b0010;
`else
      eg = 4'b0001;
`endif
      step("hold", 4'b0011, 4'b0010, eg, (eg == 4'b0010) ? 2'b01 : 2'b00, eg == 4'b0010);
    end
    step("hold_rel",     4'b0010, 4'b0010, 4'b0010, 2'b01, 1'b1);
    step("hold_idle",    4'b0000, 4'b0010, 4'b0000, 2'b01, 1'b1);

    // Lone requester past the hold limit keeps its grant.
    for (int k = 0; k < 6; k++) begin
      step("lone_sat",   4'b0001, 4'b0010, 4'b0001, 2'b00, 1'b0);
    end
    step("end_idle",     4'b0000, 4'b0010, 4'b0000, 2'b00, 1'b0);

    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
